pong_match_ctrl: RTL and testbench

//  Match sequencer for Pong. Drives the graph, timer and score datapath: starts matches, serves balls,

---
 rtl/pong_pkg.sv | 32 +++
 rtl/pong_edge_det.sv | 21 ++
 rtl/pong_match_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the Pong match logic: state codes, winner codes and key slices.
// pong_text and the rgb mux decode the same state codes, so they live here.
package pong_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SERVE = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_POINT = 3'd3;
   localparam logic [2:0] ST_PAUSE = 3'd4;
   localparam logic [2:0] ST_OVER  = 3'd5;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_L    = 2'b01;
   localparam logic [1:0] WIN_R    = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   // key[3:2] belongs to the left player, key[1:0] to the right player
   localparam int KEY_L_HI = 3;
   localparam int KEY_L_LO = 2;
   localparam int KEY_R_HI = 1;
   localparam int KEY_R_LO = 0;

   function automatic logic [1:0] decide_winner(input logic [6:0] tot_l, input logic [6:0] tot_r);
      if (tot_l > tot_r) begin
         return WIN_L;
      end else if (tot_r > tot_l) begin
         return WIN_R;
      end
      return WIN_TIE;
   endfunction

endpackage

// File: rtl/pong_edge_det.sv
// One-flop rising-edge detector; the edge output is combinational on the live input.
module pong_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic din_q_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         din_q_reg <= 1'b0;
      end else begin
         din_q_reg <= din;
      end
   end

   assign rise = din & ~din_q_reg;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point/pause/over flow, ball count, hit totals and winner.
// All outputs come straight from flops; pulses appear one cycle after their cause.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int BALLS    = 3,
   parameter int HOLD_MAX = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key,
   input  logic       pause_key,
   input  logic [1:0] hit,
   input  logic       miss,
   input  logic       timer_up,
   output logic       gra_still,
   output logic       timer_start,
   output logic [1:0] d_inc,
   output logic       d_clr,
   output logic [1:0] balls_left,
   output logic [1:0] winner,
   output logic [2:0] state
);

   localparam logic [1:0] BALLS_INIT = 2'(BALLS);
   localparam logic [6:0] TOT_MAX    = 7'(HOLD_MAX);

   logic [2:0]       state_reg, state_next;
   logic             armed_reg, armed_next;
   logic [1:0]       balls_reg, balls_next;
   logic [1:0][6:0]  tot_reg, tot_inc, tot_next;
   logic [1:0]       winner_reg, winner_next;
   logic [1:0]       d_inc_reg, d_inc_next;
   logic             gra_still_reg, gra_still_next;
   logic             d_clr_reg, d_clr_next;
   logic             timer_start_reg, timer_start_next;
   logic             pause_rise, any_key, both_keys, timer_ok, ball_dec;

   pong_edge_det u_pause_edge (
      .clk   (clk),
      .reset (reset),
      .din   (pause_key),
      .rise  (pause_rise)
   );

   assign any_key   = |key;
   assign both_keys = (|key[KEY_L_HI:KEY_L_LO]) & (|key[KEY_R_HI:KEY_R_LO]);
   // A timer_up left over from a previous run is ignored until our own start has been seen
   assign timer_ok  = timer_up & armed_reg;

   // Index 0 is the right player, index 1 the left, matching the hit bit order
   for (genvar gi = 0; gi < 2; gi++) begin : g_tot
      assign tot_inc[gi] = (state_reg == ST_PLAY && hit[gi] && tot_reg[gi] < TOT_MAX)
                           ? tot_reg[gi] + 7'd1 : tot_reg[gi];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         armed_reg       <= 1'b0;
         balls_reg       <= BALLS_INIT;
         tot_reg         <= '0;
         winner_reg      <= WIN_NONE;
         d_inc_reg       <= 2'b00;
         gra_still_reg   <= 1'b1;
         d_clr_reg       <= 1'b1;
         timer_start_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         armed_reg       <= armed_next;
         balls_reg       <= balls_next;
         tot_reg         <= tot_next;
         winner_reg      <= winner_next;
         d_inc_reg       <= d_inc_next;
         gra_still_reg   <= gra_still_next;
         d_clr_reg       <= d_clr_next;
         timer_start_reg <= timer_start_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ball_dec   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (any_key) begin
               state_next = ST_SERVE;
               ball_dec   = 1'b1;
            end
         end
         ST_SERVE: begin
            if (timer_ok && both_keys) begin
               state_next = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (miss) begin
               if (balls_reg == 2'd0) begin
                  state_next = ST_OVER;
               end else begin
                  state_next = ST_POINT;
                  ball_dec   = 1'b1;
               end
            end else if (pause_rise) begin
               state_next = ST_PAUSE;
            end
         end
         ST_POINT: begin
            if (timer_ok) begin
               state_next = ST_SERVE;
            end
         end
         ST_PAUSE: begin
            if (pause_rise) begin
               state_next = ST_PLAY;
            end
         end
         ST_OVER: begin
            if (timer_ok) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      balls_next  = ball_dec ? balls_reg - 2'd1 : balls_reg;
      tot_next    = tot_inc;
      winner_next = winner_reg;
      d_inc_next  = (state_reg == ST_PLAY) ? hit : 2'b00;
      // Winner includes a hit that lands in the same cycle as the final miss
      if (state_next == ST_OVER && state_reg != ST_OVER) begin
         winner_next = decide_winner(tot_inc[1], tot_inc[0]);
      end
      if (state_next == ST_IDLE) begin
         balls_next  = BALLS_INIT;
         tot_next    = '0;
         winner_next = WIN_NONE;
      end
      gra_still_next   = (state_next != ST_PLAY);
      d_clr_next       = (state_next == ST_IDLE);
      timer_start_next = (state_next != state_reg) &&
                         (state_next == ST_SERVE || state_next == ST_POINT || state_next == ST_OVER);
      armed_next       = (state_next != state_reg) ? 1'b0 : (armed_reg | timer_start_reg);
   end

   always_ff @(posedge clk) begin
      if (!reset && ball_dec) begin
         assert (balls_reg != 2'd0);
      end
   end

   assign state       = state_reg;
   assign balls_left  = balls_reg;
   assign winner      = winner_reg;
   assign d_inc       = d_inc_reg;
   assign gra_still   = gra_still_reg;
   assign d_clr       = d_clr_reg;
   assign timer_start = timer_start_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: match-level model checked every cycle plus directed literal checks.
module tb_pong_match_ctrl;

   localparam int BALLS    = 3;
   localparam int HOLD_MAX = 99;

   logic       clk;
   logic       reset;
   logic [3:0] key;
   logic       pause_key;
   logic [1:0] hit;
   logic       miss;
   logic       timer_up;
   logic       gra_still;
   logic       timer_start;
   logic [1:0] d_inc;
   logic       d_clr;
   logic [1:0] balls_left;
   logic [1:0] winner;
   logic [2:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   pong_match_ctrl #(.BALLS(BALLS), .HOLD_MAX(HOLD_MAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .key         (key),
      .pause_key   (pause_key),
      .hit         (hit),
      .miss        (miss),
      .timer_up    (timer_up),
      .gra_still   (gra_still),
      .timer_start (timer_start),
      .d_inc       (d_inc),
      .d_clr       (d_clr),
      .balls_left  (balls_left),
      .winner      (winner),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Match model: states numbered 0 idle,1 serve,2 play,3 point,4 pause,5 over.
   // m_age counts cycles spent in the current state; the timer is trusted from age 1.
   int         m_state, m_balls, m_tl, m_tr, m_win, m_age;
   logic [1:0] m_dinc;
   logic       m_ts, m_pq, started;

   initial started = 1'b0;

   always @(posedge clk) begin : model
      int   ns, nb, ntl, ntr, nw;
      logic prise, tu_ok;
      if (reset) begin
         m_state <= 0; m_balls <= BALLS; m_tl <= 0; m_tr <= 0; m_win <= 0;
         m_age <= 0; m_dinc <= 2'b00; m_ts <= 1'b0; m_pq <= 1'b0;
         started <= 1'b1;
      end else begin
         prise = pause_key && !m_pq;
         tu_ok = timer_up && (m_age >= 1);
         ns = m_state; nb = m_balls; ntl = m_tl; ntr = m_tr; nw = m_win;
         m_dinc <= 2'b00;
         if (m_state == 0 && key != 4'b0000) begin
            ns = 1; nb = m_balls - 1;
         end else if (m_state == 1 && tu_ok && key[3:2] != 2'b00 && key[1:0] != 2'b00) begin
            ns = 2;
         end else if (m_state == 2) begin
            m_dinc <= hit;
            if (hit[1]) ntl = (m_tl + 1 > HOLD_MAX) ? HOLD_MAX : m_tl + 1;
            if (hit[0]) ntr = (m_tr + 1 > HOLD_MAX) ? HOLD_MAX : m_tr + 1;
            if (miss && m_balls == 0) begin
               ns = 5;
               nw = (ntl > ntr) ? 1 : (ntr > ntl) ? 2 : 3;
            end else if (miss) begin
               ns = 3; nb = m_balls - 1;
            end else if (prise) begin
               ns = 4;
            end
         end else if (m_state == 3 && tu_ok) begin
            ns = 1;
         end else if (m_state == 4 && prise) begin
            ns = 2;
         end else if (m_state == 5 && tu_ok) begin
            ns = 0;
         end
         if (ns == 0) begin
            nb = BALLS; ntl = 0; ntr = 0; nw = 0;
         end
         m_ts    <= (ns != m_state) && (ns == 1 || ns == 3 || ns == 5);
         m_age   <= (ns != m_state) ? 0 : m_age + 1;
         m_state <= ns; m_balls <= nb; m_tl <= ntl; m_tr <= ntr; m_win <= nw;
         m_pq    <= pause_key;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("m_state",       int'(state),          m_state);
         check("m_balls_left",  int'(balls_left),     m_balls);
         check("m_winner",      int'(winner),         m_win);
         check("m_gra_still",   int'(gra_still),      int'(m_state != 2));
         check("m_d_clr",       int'(d_clr),          int'(m_state == 0));
         check("m_timer_start", int'(timer_start),    int'(m_ts));
         check("m_d_inc",       int'(d_inc),          int'(m_dinc));
         check("m_total_left",  int'(dut.tot_reg[1]), m_tl);
         check("m_total_right", int'(dut.tot_reg[0]), m_tr);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Call on SERVE entry: stale-timer cycle, then both players hold a key
   task automatic serve_to_play(input string nm);
      timer_up = 1'b1; key = 4'b0101;
      step(2);
      timer_up = 1'b0; key = 4'b0000;
      check(nm, int'(state), 2);
   endtask

   task automatic game(input int nl, input int nr, input int exp_win, input string nm);
      key = 4'b0010; step(1); key = 4'b0000;
      serve_to_play({nm, "_play"});
      for (int i = 0; i < nl; i++) begin hit = 2'b10; step(1); end
      for (int i = 0; i < nr; i++) begin hit = 2'b01; step(1); end
      hit = 2'b00;
      for (int b = 0; b < 3; b++) begin
         miss = 1'b1; step(1); miss = 1'b0;
         if (b < 2) begin
            timer_up = 1'b1; step(2); timer_up = 1'b0;
            serve_to_play({nm, "_reserve"});
         end
      end
      check({nm, "_over"}, int'(state), 5);
      check({nm, "_winner"}, int'(winner), exp_win);
      timer_up = 1'b1; step(2); timer_up = 1'b0;
      check({nm, "_idle"}, int'(state), 0);
   endtask

   initial begin
      reset = 1'b1; key = 4'b0000; pause_key = 1'b0; hit = 2'b00; miss = 1'b0; timer_up = 1'b0;
      step(2);
      reset = 1'b0;
      check("rst_state", int'(state), 0);
      check("rst_balls", int'(balls_left), 3);
      check("rst_d_clr", int'(d_clr), 1);
      check("rst_gra_still", int'(gra_still), 1);
      check("rst_winner", int'(winner), 0);

      // 1: key press starts a match
      key = 4'b0100; step(1); key = 4'b0000;
      check("t1_state", int'(state), 1);
      check("t1_balls", int'(balls_left), 2);
      check("t1_timer_start", int'(timer_start), 1);
      check("t1_d_clr", int'(d_clr), 0);
      step(1);
      check("t1_ts_single", int'(timer_start), 0);

      // 2: only one player holding a key keeps us in SERVE
      timer_up = 1'b1; key = 4'b0100; step(1);
      check("t2_one_key", int'(state), 1);
      key = 4'b0101; step(1);
      check("t2_play", int'(state), 2);
      check("t2_gra_still", int'(gra_still), 0);
      timer_up = 1'b0; key = 4'b0000;

      // 3: simultaneous hits, then hit together with miss
      hit = 2'b11; step(1); hit = 2'b00;
      check("t3_d_inc_both", int'(d_inc), 3);
      step(1);
      check("t3_d_inc_clear", int'(d_inc), 0);
      check("t3_tot_l", int'(dut.tot_reg[1]), 1);
      check("t3_tot_r", int'(dut.tot_reg[0]), 1);
      hit = 2'b10; miss = 1'b1; step(1); hit = 2'b00; miss = 1'b0;
      check("t3_hit_miss_dinc", int'(d_inc), 2);
      check("t3_hit_miss_state", int'(state), 3);
      check("t3_miss_ts", int'(timer_start), 1);
      check("t3_balls", int'(balls_left), 1);
      timer_up = 1'b1; step(1);
      check("t3_stale_timer", int'(state), 3);
      step(1);
      check("t3_point_to_serve", int'(state), 1);
      check("t3_serve_ts", int'(timer_start), 1);
      serve_to_play("t3_replay");
      hit = 2'b11; step(1); hit = 2'b11; step(1); hit = 2'b10; step(1); hit = 2'b00;

      // 5: long pause press gives one edge; miss and hit ignored while paused
      pause_key = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) miss = 1'b1;
         if (i == 6) hit = 2'b01;
         step(1);
         miss = 1'b0; hit = 2'b00;
         if (i == 0) check("t5_pause_enter", int'(state), 4);
      end
      check("t5_pause_hold", int'(state), 4);
      check("t5_pause_balls", int'(balls_left), 1);
      pause_key = 1'b0; step(1);
      pause_key = 1'b1; step(1);
      check("t5_pause_exit", int'(state), 2);
      pause_key = 1'b0;

      // 4: remaining balls, left 5 vs right 3
      miss = 1'b1; step(1); miss = 1'b0;
      check("t4_point2", int'(state), 3);
      check("t4_balls0", int'(balls_left), 0);
      timer_up = 1'b1; step(2); timer_up = 1'b0;
      serve_to_play("t4_replay");
      miss = 1'b1; step(1); miss = 1'b0;
      check("t4_over", int'(state), 5);
      check("t4_winner_left", int'(winner), 1);
      timer_up = 1'b1; step(1);
      check("t4_over_stale", int'(state), 5);
      step(1); timer_up = 1'b0;
      check("t4_idle", int'(state), 0);
      check("t4_balls_reload", int'(balls_left), 3);
      check("t4_winner_clr", int'(winner), 0);

      // 6: saturate totals, pause, then reset mid-match
      key = 4'b0001; step(1); key = 4'b0000;
      serve_to_play("t6_play");
      for (int i = 0; i < 101; i++) begin hit = 2'b11; step(1); end
      hit = 2'b00; step(1);
      check("t6_sat_l", int'(dut.tot_reg[1]), 99);
      check("t6_sat_r", int'(dut.tot_reg[0]), 99);
      pause_key = 1'b1; step(1);
      check("t6_pause", int'(state), 4);
      reset = 1'b1; step(1);
      reset = 1'b0; pause_key = 1'b0;
      check("t6_rst_state", int'(state), 0);
      check("t6_rst_tot_l", int'(dut.tot_reg[1]), 0);
      check("t6_rst_tot_r", int'(dut.tot_reg[0]), 0);
      check("t6_rst_winner", int'(winner), 0);
      check("t6_rst_d_clr", int'(d_clr), 1);
      check("t6_rst_balls", int'(balls_left), 3);

      // Right-player win and a tie
      game(0, 2, 2, "g_right");
      game(1, 1, 3, "g_tie");

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
